// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state names, the IF/ID
// pipeline register layout and the PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pred_taken;
    logic [31:0] pred_target;
  } if_id_t;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Instructions are word aligned; drop the two byte-offset bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_next_pc_mux.sv
// Next-PC selection for the fetch stage. Pure combinational; the priority is
// mispredict redirect, then stall (hold), then accepted fetch (BTB target or
// sequential), otherwise hold.
module fetch_next_pc_mux
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        mispred_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  input  logic        accept_i,
  input  logic        btb_hit_i,
  input  logic [31:0] btb_target_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pcplus4_o,
  output logic [31:0] btb_target_aligned_o
);

  // PC+4 wraps modulo 2^32 through plain 32-bit addition.
  assign pcplus4_o            = pc_i + 32'd4;
  assign btb_target_aligned_o = align_pc(btb_target_i);

  // Pick the PC to fetch next cycle.
  always_comb begin
    next_pc_o = pc_i;
    if (mispred_i) begin
      next_pc_o = align_pc(redirect_pc_i);
    end else if (!stall_i && accept_i) begin
      next_pc_o = btb_hit_i ? btb_target_aligned_o : pcplus4_o;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and IF/ID pipeline register.
//
// Instruction memory handshake: imem_req_o is the request valid and
// imem_gnt_i the acceptance. A fetch completes (accept) only in a cycle where
// both are high; the request is a pure function of the FSM state, stall_i and
// rst_i, never of imem_gnt_i, and the PC is held stable while a request waits
// for its grant. A mispredict abandons any ungranted request.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int          INDEX_WIDTH = 6,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stall_i,
  input  logic                        EXMEM_mispred_i,
  input  logic [31:0]                 EXMEM_redirect_pc_i,
  input  logic                        IF_btb_hit_i,
  input  logic [31:0]                 IF_btb_rd_target_i,
  input  logic                        imem_gnt_i,
  output logic                        imem_req_o,
  output logic [31:0]                 IF_pc_o,
  output logic [INDEX_WIDTH-1:0]      IF_btb_rd_index_o,
  output logic [31-INDEX_WIDTH-2:0]   IF_PC_tag_o,
  output logic                        ID_valid_o,
  output logic [31:0]                 ID_pc_o,
  output logic [31:0]                 ID_pcplus4_o,
  output logic                        ID_pred_taken_o,
  output logic [31:0]                 ID_pred_target_o,
  output logic [CNT_WIDTH-1:0]        redirect_cnt_o,
  output logic [1:0]                  dbg_state_o
);

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_WAIT  = WAIT;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [31:0]          pc;
  logic [31:0]          next_pc;
  logic [31:0]          pcplus4;
  logic [31:0]          target_aligned;
  logic                 accept;
  if_id_t               id_q;
  logic [CNT_WIDTH-1:0] cnt;

  // rst_i gates the request so a reset arriving mid-WAIT drops it at once.
  assign imem_req_o = (state != ST_BOOT) & ~stall_i & ~rst_i;
  assign accept     = imem_req_o & imem_gnt_i;

  fetch_next_pc_mux u_next_pc_mux (
    .pc_i                 (pc),
    .mispred_i            (EXMEM_mispred_i),
    .redirect_pc_i        (EXMEM_redirect_pc_i),
    .stall_i              (stall_i),
    .accept_i             (accept),
    .btb_hit_i            (IF_btb_hit_i),
    .btb_target_i         (IF_btb_rd_target_i),
    .next_pc_o            (next_pc),
    .pcplus4_o            (pcplus4),
    .btb_target_aligned_o (target_aligned)
  );

  // FSM next state: BOOT lasts one cycle, WAIT tracks an outstanding request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: if (!EXMEM_mispred_i && imem_req_o && !imem_gnt_i) state_nxt = ST_WAIT;
      ST_WAIT:  if (EXMEM_mispred_i || imem_gnt_i) state_nxt = ST_FETCH;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Fetch PC register; the mux already resolves mispredict/stall/accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  // IF/ID register: flush on mispredict, hold on stall, load on accept,
  // otherwise insert a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q <= '0;
    end else if (EXMEM_mispred_i) begin
      id_q.valid <= 1'b0;
    end else if (stall_i) begin
      id_q <= id_q;
    end else if (accept) begin
      id_q.valid       <= 1'b1;
      id_q.pc          <= pc;
      id_q.pcplus4     <= pcplus4;
      id_q.pred_taken  <= IF_btb_hit_i;
      id_q.pred_target <= IF_btb_hit_i ? target_aligned : pcplus4;
    end else begin
      id_q.valid <= 1'b0;
    end
  end

  // Saturating count of mispredict redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (EXMEM_mispred_i && (cnt != {CNT_WIDTH{1'b1}})) cnt <= cnt + 1'b1;
  end

  assign IF_pc_o           = pc;
  assign IF_btb_rd_index_o = pc[INDEX_WIDTH+1:2];
  assign IF_PC_tag_o       = pc[31:INDEX_WIDTH+2];
  assign ID_valid_o        = id_q.valid;
  assign ID_pc_o           = id_q.pc;
  assign ID_pcplus4_o      = id_q.pcplus4;
  assign ID_pred_taken_o   = id_q.pred_taken;
  assign ID_pred_target_o  = id_q.pred_target;
  assign redirect_cnt_o    = cnt;
  assign dbg_state_o       = state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed steps followed by random
// traffic, all compared against a behavioural model of the fetch stage.
module tb_fetch_pc_unit;

  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        EXMEM_mispred_i = 1'b0;
  logic [31:0] EXMEM_redirect_pc_i = '0;
  logic        IF_btb_hit_i = 1'b0;
  logic [31:0] IF_btb_rd_target_i = '0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] IF_pc_o;
  logic [5:0]  IF_btb_rd_index_o;
  logic [23:0] IF_PC_tag_o;
  logic        ID_valid_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pcplus4_o;
  logic        ID_pred_taken_o;
  logic [31:0] ID_pred_target_o;
  logic [15:0] redirect_cnt_o;
  logic [1:0]  dbg_state_o;

  fetch_pc_unit dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .stall_i             (stall_i),
    .EXMEM_mispred_i     (EXMEM_mispred_i),
    .EXMEM_redirect_pc_i (EXMEM_redirect_pc_i),
    .IF_btb_hit_i        (IF_btb_hit_i),
    .IF_btb_rd_target_i  (IF_btb_rd_target_i),
    .imem_gnt_i          (imem_gnt_i),
    .imem_req_o          (imem_req_o),
    .IF_pc_o             (IF_pc_o),
    .IF_btb_rd_index_o   (IF_btb_rd_index_o),
    .IF_PC_tag_o         (IF_PC_tag_o),
    .ID_valid_o          (ID_valid_o),
    .ID_pc_o             (ID_pc_o),
    .ID_pcplus4_o        (ID_pcplus4_o),
    .ID_pred_taken_o     (ID_pred_taken_o),
    .ID_pred_target_o    (ID_pred_target_o),
    .redirect_cnt_o      (redirect_cnt_o),
    .dbg_state_o         (dbg_state_o)
  );

  int checks = 0;
  int errors = 0;
  bit do_check = 1'b1;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_valid;
  logic [31:0] m_idpc, m_idp4, m_tgt;
  bit          m_taken;
  logic [15:0] m_cnt;

  // Scoreboard: PCs of accepted fetches, expected in ID one cycle later
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] pcv;
    chk("req",       {31'd0, imem_req_o}, {31'd0, (!rst_i && !m_boot && !stall_i)});
    chk("if_pc",     IF_pc_o, m_pc);
    chk("btb_index", {26'd0, IF_btb_rd_index_o}, (m_pc / 4) % 64);
    chk("pc_tag",    {8'd0, IF_PC_tag_o}, m_pc / 256);
    chk("id_valid",  {31'd0, ID_valid_o}, {31'd0, m_valid});
    chk("id_pc",     ID_pc_o, m_idpc);
    chk("id_pcp4",   ID_pcplus4_o, m_idp4);
    chk("id_taken",  {31'd0, ID_pred_taken_o}, {31'd0, m_taken});
    chk("id_target", ID_pred_target_o, m_tgt);
    chk("redir_cnt", {16'd0, redirect_cnt_o}, {16'd0, m_cnt});
    if (exp_q.size() > 0) begin
      pcv = exp_q.pop_front();
      chk("sb_id_pc", ID_pc_o, pcv);
      chk("sb_id_valid", {31'd0, ID_valid_o}, 32'd1);
    end
  endtask

  task automatic model_step(input bit rst, input bit stall, input bit mis,
                            input logic [31:0] redir, input bit hit,
                            input logic [31:0] tgt, input bit gnt);
    bit acc;
    if (rst) begin
      m_pc = 32'h0; m_boot = 1; m_valid = 0; m_idpc = 0; m_idp4 = 0;
      m_taken = 0; m_tgt = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      acc = !m_boot && !stall && gnt;
      if (mis) begin
        m_pc = redir & MASK;
        m_valid = 0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (stall) begin
        // everything holds
      end else if (acc) begin
        exp_q.push_back(m_pc);
        m_valid = 1;
        m_idpc  = m_pc;
        m_idp4  = m_pc + 32'd4;
        m_taken = hit;
        m_tgt   = hit ? (tgt & MASK) : m_pc + 32'd4;
        m_pc    = hit ? (tgt & MASK) : m_pc + 32'd4;
      end else begin
        m_valid = 0;
      end
      m_boot = 0;
    end
  endtask

  // Driver: apply one cycle of inputs, check outputs, advance model and clock.
  // Entered and left at posedge+2, so registered outputs are settled on return.
  task automatic cyc(input bit rst, input bit stall, input bit mis,
                     input logic [31:0] redir, input bit hit,
                     input logic [31:0] tgt, input bit gnt);
    rst_i = rst; stall_i = stall; EXMEM_mispred_i = mis;
    EXMEM_redirect_pc_i = redir; IF_btb_hit_i = hit;
    IF_btb_rd_target_i = tgt; imem_gnt_i = gnt;
    #1;
    if (do_check) check_all();
    model_step(rst, stall, mis, redir, hit, tgt, gnt);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_pc = 0; m_boot = 1; m_valid = 0; m_idpc = 0; m_idp4 = 0;
    m_taken = 0; m_tgt = 0; m_cnt = 0;
    do_check = 0;
    @(posedge clk); #2;
    do_reset();
    do_check = 1;

    // Reset: first cycle after release is BOOT with no request
    rst_i = 0; #1;
    chk("rst_pc", IF_pc_o, 32'h0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("boot_req", {31'd0, imem_req_o}, 32'd1);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq_if_pc", IF_pc_o, 32'(4 * i));
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("seq_id_pc", ID_pc_o, 32'(4 * i));
      chk("seq_id_valid", {31'd0, ID_valid_o}, 32'd1);
    end

    // BTB hit at PC 0x10
    chk("hit_pre_pc", IF_pc_o, 32'h10);
    cyc(0, 0, 0, 0, 1, 32'h200, 1);
    chk("hit_if_pc", IF_pc_o, 32'h200);
    chk("hit_taken", {31'd0, ID_pred_taken_o}, 32'd1);
    chk("hit_target", ID_pred_target_o, 32'h200);

    // Mispredict during stall
    cyc(0, 1, 1, 32'h44, 0, 0, 1);
    chk("mis_pc", IF_pc_o, 32'h44);
    chk("mis_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("mis_cnt", {16'd0, redirect_cnt_o}, 32'd1);

    // Grant wait: three ungranted cycles, then the grant
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("wait_pc", IF_pc_o, 32'h44);
      chk("wait_valid", {31'd0, ID_valid_o}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wait_acc_valid", {31'd0, ID_valid_o}, 32'd1);
    chk("wait_acc_pc", ID_pc_o, 32'h44);

    // Wrap-around of PC+4 and redirect alignment
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc", IF_pc_o, 32'h0);
    chk("wrap_pcp4", ID_pcplus4_o, 32'h0);
    cyc(0, 0, 1, 32'h47, 0, 0, 1);
    chk("align_pc", IF_pc_o, 32'h44);
    cyc(0, 0, 0, 0, 1, 32'h303, 1);
    chk("btb_align_pc", IF_pc_o, 32'h300);

    // Mispredict in the BOOT cycle
    do_reset();
    cyc(0, 0, 1, 32'h120, 0, 0, 1);
    chk("boot_mis_pc", IF_pc_o, 32'h120);
    chk("boot_mis_cnt", {16'd0, redirect_cnt_o}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("boot_mis_id", ID_pc_o, 32'h120);

    // Reset arriving mid-WAIT drops the request immediately
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1; imem_gnt_i = 1; #1;
    chk("rst_wait_req", {31'd0, imem_req_o}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("rst_wait_pc", IF_pc_o, 32'h0);
    chk("rst_wait_valid", {31'd0, ID_valid_o}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          $urandom(),
          $urandom_range(0, 2) == 0,
          $urandom(),
          $urandom_range(0, 1) == 1);
    end

    // Counter saturation
    exp_q.delete();
    do_check = 0;
    for (int i = 0; i < 65536; i++) cyc(0, 0, 1, 32'h80, 0, 0, 1);
    do_check = 1;
    chk("sat_cnt", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
    cyc(0, 0, 1, 32'h80, 0, 0, 1);
    chk("sat_hold", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
    cyc(0, 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
